// File: rtl/vip_pkg.sv
// Shared definitions for the VIP frame stream generator: FSM state
// encoding, default video timing and small width helpers.
package vip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBLANK = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_DONE   = 3'd5
  } vip_state_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_H_BLANK  = 16;
  localparam int DEF_V_BLANK  = 8;
  localparam int DEF_VS_LEN   = 4;

  // Bits needed to index n distinct values (never less than one bit).
  function automatic int bits_for(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  function automatic int max2(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/vip_timing_counter.sv
// Loadable down-counter shared by every timed FSM state. The count parks
// at zero; tc_o flags the last cycle of the interval that was loaded.
module vip_timing_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Reload on request, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/vip_frame_stream_gen_8bit.sv
// Frame stream generator: reads one frame of 8-bit pixels from a linear
// memory and replays it as a vsync / href / clken video stream.
// Optional build macro VIP_STREAM_TESTPAT_EN adds a test_mode input that
// replaces memory data with a (column+line) ramp and suppresses reads.
module vip_frame_stream_gen_8bit
  import vip_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int V_BLANK  = DEF_V_BLANK,
  parameter int VS_LEN   = DEF_VS_LEN
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
`ifdef VIP_STREAM_TESTPAT_EN
  input  logic                                     test_mode,
`endif
  input  logic [7:0]                               pix_rdata,
  output logic                                     pix_rd,
  output logic [bits_for(H_ACTIVE*V_ACTIVE)-1:0]   pix_raddr,
  output logic                                     post_frame_vsync,
  output logic                                     post_frame_href,
  output logic                                     post_frame_clken,
  output logic [7:0]                               post_img_y,
  output logic                                     busy,
  output logic                                     frame_done
);

  localparam int ADDR_W = bits_for(H_ACTIVE * V_ACTIVE);
  localparam int LINE_W = bits_for(V_ACTIVE);
  localparam int CNT_W  = bits_for(max2(max2(H_ACTIVE, H_BLANK), max2(V_BLANK, VS_LEN)));

  // Counter reload values: an interval of N cycles loads N-1.
  localparam logic [CNT_W-1:0]  LD_VS     = CNT_W'(VS_LEN - 1);
  localparam logic [CNT_W-1:0]  LD_VB     = CNT_W'(V_BLANK - 1);
  localparam logic [CNT_W-1:0]  LD_ACT    = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0]  LD_HB     = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0]  LD_ZERO   = {CNT_W{1'b0}};
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_ACTIVE - 1);

  vip_state_e        state_q, state_d;
  logic              cnt_load_s;
  logic [CNT_W-1:0]  cnt_val_s;
  logic              cnt_tc_s;
  logic              tm_s;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              vs_q, href_q;

`ifdef VIP_STREAM_TESTPAT_EN
  assign tm_s = test_mode;
`else
  assign tm_s = 1'b0;
`endif

  vip_timing_counter #(
    .W(CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_val_s),
    .tc_o       (cnt_tc_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; every transition reloads the timer with the new state's length.
  always_comb begin
    state_d    = state_q;
    cnt_load_s = 1'b0;
    cnt_val_s  = LD_ZERO;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_VSYNC;
          cnt_load_s = 1'b1;
          cnt_val_s  = LD_VS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VSYNC: begin
        if (cnt_tc_s) begin
          state_d    = ST_VBLANK;
          cnt_load_s = 1'b1;
          cnt_val_s  = LD_VB;
        end else begin
          state_d = ST_VSYNC;
        end
      end
      ST_VBLANK: begin
        if (cnt_tc_s) begin
          state_d    = ST_ACTIVE;
          cnt_load_s = 1'b1;
          cnt_val_s  = LD_ACT;
        end else begin
          state_d = ST_VBLANK;
        end
      end
      ST_ACTIVE: begin
        if (cnt_tc_s) begin
          state_d    = ST_HBLANK;
          cnt_load_s = 1'b1;
          cnt_val_s  = LD_HB;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_HBLANK: begin
        if (cnt_tc_s) begin
          cnt_load_s = 1'b1;
          if (line_q == LAST_LINE) begin
            state_d   = ST_DONE;
            cnt_val_s = LD_ZERO;
          end else begin
            state_d   = ST_ACTIVE;
            cnt_val_s = LD_ACT;
          end
        end else begin
          state_d = ST_HBLANK;
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        cnt_load_s = 1'b1;
        cnt_val_s  = LD_ZERO;
      end
      default: begin
        state_d    = ST_IDLE;
        cnt_load_s = 1'b1;
        cnt_val_s  = LD_ZERO;
      end
    endcase
  end

  // Next values of the state-aligned outputs and the address / line counters.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    rd_d   = (state_d == ST_ACTIVE) && !tm_s;

    if ((state_q == ST_IDLE) && (state_d == ST_VSYNC)) begin
      addr_d = {ADDR_W{1'b0}};
    end else if (rd_q) begin
      addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      addr_d = addr_q;
    end

    if ((state_q == ST_VBLANK) && (state_d == ST_ACTIVE)) begin
      line_d = {LINE_W{1'b0}};
    end else if ((state_q == ST_HBLANK) && (state_d == ST_ACTIVE)) begin
      line_d = line_q + {{(LINE_W-1){1'b0}}, 1'b1};
    end else begin
      line_d = line_q;
    end
  end

  // Registers for outputs that track the current FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= {ADDR_W{1'b0}};
      line_q <= {LINE_W{1'b0}};
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      rd_q   <= rd_d;
      addr_q <= addr_d;
      line_q <= line_d;
    end
  end

  // Stream flags lag the state by one cycle so they line up with read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q   <= 1'b0;
      href_q <= 1'b0;
    end else begin
      vs_q   <= (state_q == ST_VSYNC);
      href_q <= (state_q == ST_ACTIVE);
    end
  end

`ifdef VIP_STREAM_TESTPAT_EN
  localparam int COL_W = bits_for(H_ACTIVE);

  logic [COL_W-1:0] col_q, col_d;
  logic [7:0]       pat_q, pat_d;

  // Column tracking and ramp value for the pixel issued this cycle.
  always_comb begin
    if ((state_d == ST_ACTIVE) && (state_q != ST_ACTIVE)) begin
      col_d = {COL_W{1'b0}};
    end else if (state_q == ST_ACTIVE) begin
      col_d = col_q + {{(COL_W-1){1'b0}}, 1'b1};
    end else begin
      col_d = col_q;
    end

    if (state_q == ST_ACTIVE) begin
      pat_d = 8'(int'(col_q) + int'(line_q));
    end else begin
      pat_d = 8'h00;
    end
  end

  // Column and ramp registers; the ramp lands in the same cycle as read data would.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= {COL_W{1'b0}};
      pat_q <= 8'h00;
    end else begin
      col_q <= col_d;
      pat_q <= pat_d;
    end
  end

  // Pixel output: ramp or memory data inside a line, zero elsewhere.
  always_comb begin
    if (href_q) begin
      if (tm_s) begin
        post_img_y = pat_q;
      end else begin
        post_img_y = pix_rdata;
      end
    end else begin
      post_img_y = 8'h00;
    end
  end
`else
  // Pixel output: memory data inside a line, zero elsewhere.
  always_comb begin
    if (href_q) begin
      post_img_y = pix_rdata;
    end else begin
      post_img_y = 8'h00;
    end
  end
`endif

  assign busy             = busy_q;
  assign frame_done       = done_q;
  assign pix_rd           = rd_q;
  assign pix_raddr        = addr_q;
  assign post_frame_vsync = vs_q;
  assign post_frame_href  = href_q;
  assign post_frame_clken = href_q;

endmodule

// File: doc/vip_frame_stream_gen_8bit.md
VIP_FRAME_STREAM_GEN_8BIT -- requirements
Module: vip_frame_stream_gen_8bit

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, giving active pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 480, giving active lines per frame.
REQ-003 The block SHALL have parameter H_BLANK, default 16 (legal range >=1), giving idle cycles between lines.
REQ-004 The block SHALL have parameter V_BLANK, default 8 (legal range >=1), giving idle cycles after vsync and before the first line.
REQ-005 The block SHALL have parameter VS_LEN, default 4 (legal range >=1), giving vsync pulse width in cycles.
REQ-006 The block SHALL have the following ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame request, sampled in IDLE only
- pix_rdata  in  8  pixel read data, valid one cycle after pix_rd
- pix_rd  out  1  pixel read strobe
- pix_raddr  out  19  linear pixel address (line*H_ACTIVE + column)
- post_frame_vsync  out  1  frame sync
- post_frame_href  out  1  line valid
- post_frame_clken  out  1  pixel valid
- post_img_y  out  8  pixel data
- busy  out  1  high from start acceptance until frame_done
- frame_done  out  1  one-cycle pulse at end of frame

Function
REQ-007 The FSM SHALL have the states IDLE, VSYNC, VBLANK, ACTIVE, HBLANK, DONE.
REQ-008 IDLE with start=1 SHALL go to VSYNC next cycle; start in any other state SHALL be ignored.
REQ-009 VSYNC SHALL last exactly VS_LEN cycles, during which the internal vsync is high, then go to VBLANK.
REQ-010 VBLANK SHALL last V_BLANK cycles, then go to ACTIVE with line=0 and column=0.
REQ-011 ACTIVE SHALL last H_ACTIVE cycles per line, asserting pix_rd and incrementing pix_raddr by 1 every cycle.
REQ-012 After ACTIVE, the FSM SHALL go to HBLANK for H_BLANK cycles, then to ACTIVE (line+1), or to DONE if the finished line was V_ACTIVE-1.
REQ-013 DONE SHALL last one cycle, pulse frame_done, and return to IDLE; busy SHALL drop in the same cycle as the IDLE entry.
REQ-014 The outputs post_frame_vsync, post_frame_href and post_frame_clken SHALL be registered one cycle behind the internal state, so they align with pix_rdata.
REQ-015 In that aligned cycle, post_img_y SHALL equal pix_rdata; outside it, post_img_y SHALL be 0.
REQ-016 post_frame_clken SHALL equal post_frame_href, so each line is one contiguous burst of H_ACTIVE pixels.
REQ-017 pix_raddr SHALL reset to 0 at VSYNC entry, and SHALL hold its value when pix_rd=0.
REQ-018 The pixel count per frame SHALL be exactly H_ACTIVE*V_ACTIVE, and the last address SHALL be H_ACTIVE*V_ACTIVE-1.

Reset
REQ-019 On rst_n=0 the block SHALL enter IDLE immediately, asynchronously.
REQ-020 All outputs SHALL be 0 during reset, and all counters SHALL clear.
REQ-021 Reset mid-frame SHALL abort the frame with no frame_done pulse.
REQ-022 After reset release, the block SHALL wait for a new start.

Configuration
REQ-023 With macro VIP_STREAM_TESTPAT_EN defined, the block SHALL add input test_mode (1 bit); when test_mode=1, post_img_y SHALL be (column+line) mod 256, pix_rd SHALL stay 0, and all timing SHALL be unchanged.
REQ-024 Without VIP_STREAM_TESTPAT_EN, the test_mode port and its logic SHALL be absent.

Structure
REQ-025 The FSM state encoding and the default timing constants SHALL live in the shared package vip_pkg.
REQ-026 The block SHALL use one sub-module, vip_timing_counter, a loadable down-counter with a terminal-count flag that all state durations reuse.
REQ-027 Address width SHALL be sized from H_ACTIVE*V_ACTIVE; 19 bits covers the defaults.

Verification
REQ-028 The bench SHALL cover these scenarios, with H_ACTIVE=4, V_ACTIVE=3, H_BLANK=2, V_BLANK=2, VS_LEN=1 and memory returning data=address:
- Nominal frame: start pulse -> vsync high 1 cycle; 3 href bursts of 4 clken; post_img_y 0..11; frame_done 1 cycle after the last pixel's HBLANK; busy low after it.
- Start while busy: start asserted in ACTIVE -> no restart; exactly 12 pixels.
- Back-to-back frames: start held high -> second VSYNC begins 1 cycle after IDLE re-entry; pix_raddr restarts at 0.
- Reset mid-frame: rst_n low during line 1 -> all outputs 0 at once; no frame_done; next start yields a full 12-pixel frame.
- Alignment: each post_frame_clken cycle has post_img_y equal to the address issued on pix_rd one cycle earlier.
- Test pattern (VIP_STREAM_TESTPAT_EN, test_mode=1): line 2 outputs 2,3,4,5, and pix_rd is never asserted.
